spi_target_sync: RTL and testbench
==================================

SPI_TARGET_SYNC -- requirements
Module: spi_target_sync

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on sclk/cs/mosi (legal 2..3).
REQ-002 SHALL have port clk input 1: system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst input 1: reset, asynchronous, active-high.
REQ-004 SHALL have port sclk input 1: SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-005 SHALL have port cs input 1: chip select from master, active-low.
REQ-006 SHALL have port mosi input 1: serial data from master.
REQ-007 SHALL have port miso output 1: serial data to master.
REQ-008 SHALL have port tx_data input 8: next byte to transmit.
REQ-009 SHALL have port tx_valid input 1: tx_data offered.
REQ-010 SHALL have port tx_ready output 1: tx buffer empty; byte accepted when tx_valid&&tx_ready.
REQ-011 SHALL have port rx_data output 8: last complete received byte.
REQ-012 SHALL have port rx_valid output 1: one-clk pulse, rx_data updated.
REQ-013 SHALL have port busy output 1: high while in LOAD or SHIFT.
REQ-014 SHALL have port underrun output 1: one-clk pulse, byte boundary with empty tx buffer.
REQ-015 SHALL have port frame_err output 1: one-clk pulse, cs deasserted mid-byte.

Function
REQ-016 SHALL pass sclk, cs, mosi through SYNC_STAGES flops, then detect edges by comparing synchronized value with one extra registered copy.
REQ-017 SHALL implement FSM IDLE, LOAD, SHIFT; IDLE->LOAD on cs fall; LOAD->SHIFT next clk; SHIFT->IDLE on cs rise; any state->IDLE on cs rise.
REQ-018 SHALL, in LOAD, copy tx buffer into tx shifter and mark buffer empty; if buffer empty, load 0x00 and pulse underrun.
REQ-019 SHALL drive miso = tx shifter bit selected by bit order (REQ-030) while busy, and 0 in IDLE.
REQ-020 SHALL, on each synchronized sclk rise in SHIFT, shift mosi into rx shifter and increment 3-bit bit counter, wrapping 7->0.
REQ-021 SHALL, on the rise with bit counter 7, write assembled byte to rx_data, pulse rx_valid next clk, and set load_pending.
REQ-022 SHALL, on each synchronized sclk fall in SHIFT, reload tx shifter per REQ-018 if load_pending (then clear it), else shift by one.
REQ-023 SHALL support unbounded back-to-back bytes within one cs-low frame.
REQ-024 SHALL, on cs rise with bit counter != 0, pulse frame_err, discard partial rx byte, leave rx_data unchanged.
REQ-025 SHALL, on cs rise with bit counter == 0, return to IDLE with no flag.
REQ-026 SHALL hold tx_ready = 1 when tx buffer empty; simultaneous accept and LOAD/reload in one clk: shifter takes old buffer content, new byte is stored, tx_ready = 0.
REQ-027 SHALL require sclk high and low times each >= SYNC_STAGES+3 clk periods and cs-fall to first sclk rise >= SYNC_STAGES+4 clk periods; behaviour outside this is undefined.

Reset
REQ-028 SHALL, while rst=1, force state IDLE, synchronizers and shifters 0, bit counter 0, tx buffer empty, load_pending 0, and outputs miso=0, tx_ready=1, rx_data=0x00, rx_valid=0, busy=0, underrun=0, frame_err=0.
REQ-029 SHALL, on rst mid-frame, abandon the frame with no rx_valid or frame_err, and wait for a fresh cs fall after release (no LOAD from a cs already low).

Configuration
REQ-030 SHALL, with macro SPI_TARGET_LSB_FIRST_EN undefined, transmit and receive MSB first; with it defined, transmit and receive LSB first (miso from bit 0, rx shifts right); all timing identical.

Verification
REQ-031 SHALL cover single byte: preload tx 0xA5, master sends 0x3C -> rx_data=0x3C with one rx_valid pulse, master receives 0xA5, no flags.
REQ-032 SHALL cover 3-byte burst: tx 0x11 preloaded, 0x22/0x33 supplied on tx_ready, master sends 0x01,0x02,0x03 -> three rx_valid pulses with 0x01,0x02,0x03, master receives 0x11,0x22,0x33.
REQ-033 SHALL cover underrun: empty buffer at cs fall -> underrun pulse, master receives 0x00, rx still correct.
REQ-034 SHALL cover abort: cs rise after 5 sclk rises -> frame_err pulse, no rx_valid, rx_data unchanged, busy=0.
REQ-035 SHALL cover rst asserted mid-byte then released with cs low -> all outputs at reset values, no activity until next cs fall.
REQ-036 SHALL cover SPI_TARGET_LSB_FIRST_EN defined: tx 0x01, master sends 0x80 LSB-first -> first miso bit 1, rx_data=0x80.

Source files
------------

// File: rtl/spi_target_sync.sv
// spi_target_sync: SPI mode-0 target (CPOL=0, CPHA=0) that oversamples sclk, cs and
// mosi in the clk domain. Bytes are exchanged through a one-deep transmit buffer and
// a registered receive byte, and can run back to back within one cs-low frame.
// Optional build macro: SPI_TARGET_LSB_FIRST_EN.
//   - When it is defined, both directions are LSB first.
//   - When it is undefined (default), both directions are MSB first.
module spi_target_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       underrun,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // The bit-order helpers keep the MSB/LSB choice in one place.
`ifdef SPI_TARGET_LSB_FIRST_EN
    function automatic logic tx_bit(input logic [7:0] sh);
        return sh[0];
    endfunction

    function automatic logic [7:0] tx_advance(input logic [7:0] sh);
        return sh >> 1;
    endfunction

    function automatic logic [7:0] rx_insert(input logic [7:0] sh, input logic b);
        return (sh >> 1) | {b, 7'd0};
    endfunction
`else
    function automatic logic tx_bit(input logic [7:0] sh);
        return sh[7];
    endfunction

    function automatic logic [7:0] tx_advance(input logic [7:0] sh);
        return sh << 1;
    endfunction

    function automatic logic [7:0] rx_insert(input logic [7:0] sh, input logic b);
        return (sh << 1) | {7'd0, b};
    endfunction
`endif

    // Synchronizer chains plus one delayed copy of each synchronized level
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q,   cs_prev_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;

    // Core state
    state_t     state_q, state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       load_pending_q, load_pending_d;
    logic [7:0] buf_q, buf_d;
    logic       buf_full_q, buf_full_d;

    // Registered outputs
    logic       miso_q, miso_d;
    logic       tx_ready_q, tx_ready_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       busy_q, busy_d;
    logic       underrun_q, underrun_d;
    logic       frame_err_q, frame_err_d;

    logic load_s;
    logic accept_s;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise_s = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_s & sclk_prev_q;
    assign cs_rise_s   = cs_s & ~cs_prev_q;
    assign cs_fall_s   = ~cs_s & cs_prev_q;

    assign accept_s = tx_valid & tx_ready_q;

    // Shift the raw pins into the synchronizers and remember the last synchronized level
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
    end

    // Next state, shifters, buffer and output flags
    always_comb begin
        state_d        = state_q;
        tx_shift_d     = tx_shift_q;
        rx_shift_d     = rx_shift_q;
        bit_cnt_d      = bit_cnt_q;
        load_pending_d = load_pending_q;
        buf_d          = buf_q;
        buf_full_d     = buf_full_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        underrun_d     = 1'b0;
        frame_err_d    = 1'b0;
        load_s         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                bit_cnt_d      = 3'd0;
                rx_shift_d     = 8'h00;
                load_pending_d = 1'b0;
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                end else begin
                    load_s  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    // End of frame: a partial byte is dropped and flagged.
                    state_d        = ST_IDLE;
                    bit_cnt_d      = 3'd0;
                    rx_shift_d     = 8'h00;
                    load_pending_d = 1'b0;
                    if (bit_cnt_q != 3'd0) begin
                        frame_err_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b0;
                    end
                end else if (sclk_rise_s) begin
                    rx_shift_d = rx_insert(rx_shift_q, mosi_s);
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d      = rx_insert(rx_shift_q, mosi_s);
                        rx_valid_d     = 1'b1;
                        load_pending_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b0;
                    end
                end else if (sclk_fall_s) begin
                    // The fall after a completed byte presents the next byte's first bit.
                    if (load_pending_q) begin
                        load_s         = 1'b1;
                        load_pending_d = 1'b0;
                    end else begin
                        tx_shift_d = tx_advance(tx_shift_q);
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Moving the buffer into the shifter empties it; an empty buffer sends zeros.
        if (load_s) begin
            buf_full_d = 1'b0;
            if (buf_full_q) begin
                tx_shift_d = buf_q;
            end else begin
                tx_shift_d = 8'h00;
                underrun_d = 1'b1;
            end
        end else begin
            underrun_d = 1'b0;
        end

        // A byte accepted in the same clk as a load lands in the freshly emptied buffer.
        if (accept_s) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end else begin
            buf_d = buf_q;
        end

        busy_d     = (state_d != ST_IDLE);
        miso_d     = (state_d != ST_IDLE) ? tx_bit(tx_shift_d) : 1'b0;
        tx_ready_d = ~buf_full_d;
    end

    // Synchronizer and edge-history registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            cs_sync_q   <= {SYNC_STAGES{1'b0}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    // FSM state, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            tx_shift_q     <= 8'h00;
            rx_shift_q     <= 8'h00;
            bit_cnt_q      <= 3'd0;
            load_pending_q <= 1'b0;
            buf_q          <= 8'h00;
            buf_full_q     <= 1'b0;
            miso_q         <= 1'b0;
            tx_ready_q     <= 1'b1;
            rx_data_q      <= 8'h00;
            rx_valid_q     <= 1'b0;
            busy_q         <= 1'b0;
            underrun_q     <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            tx_shift_q     <= tx_shift_d;
            rx_shift_q     <= rx_shift_d;
            bit_cnt_q      <= bit_cnt_d;
            load_pending_q <= load_pending_d;
            buf_q          <= buf_d;
            buf_full_q     <= buf_full_d;
            miso_q         <= miso_d;
            tx_ready_q     <= tx_ready_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            busy_q         <= busy_d;
            underrun_q     <= underrun_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign miso      = miso_q;
    assign tx_ready  = tx_ready_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = busy_q;
    assign underrun  = underrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_target_sync.sv
// Directed testbench for spi_target_sync: acts as an SPI mode-0 master and checks
// received bytes, transmitted bytes and the status pulses against hand-computed values.
module tb_spi_target_sync;

    localparam int HALF = 8;  // sclk half period in clk cycles

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       underrun;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;

    int         rxv_cnt  = 0;
    int         und_cnt  = 0;
    int         ferr_cnt = 0;
    logic [7:0] rx_log [16];

    spi_target_sync #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .underrun  (underrun),
        .frame_err (frame_err)
    );

    // System clock, 10 ns period
    always #5 clk = ~clk;

    // Count status pulses and log every received byte
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rxv_cnt % 16] <= rx_data;
            rxv_cnt              <= rxv_cnt + 1;
        end
        if (underrun) begin
            und_cnt <= und_cnt + 1;
        end
        if (frame_err) begin
            ferr_cnt <= ferr_cnt + 1;
        end
    end

    // Safety net against a hung run
    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Offer one byte to an empty buffer for a single clk
    task automatic preload(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Wait (bounded) for room in the buffer, then hand over one byte
    task automatic supply(input logic [7:0] b);
        int n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            check("supply_wait", {31'd0, tx_ready}, 32'd1);
        end else begin
            tx_data  = b;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    // One cs-low frame of nbits. The last sclk fall coincides with cs rise so no
    // trailing reload of the tx shifter is triggered after the final byte.
    task automatic spi_frame(input logic [23:0] data, input int nbits,
                             output logic [23:0] got, output logic first_bit);
        int idx;
        got       = 24'h000000;
        first_bit = 1'b0;
        cs        = 1'b0;
        for (int i = 0; i < nbits; i++) begin
`ifdef SPI_TARGET_LSB_FIRST_EN
            idx = i;
`else
            idx = nbits - 1 - i;
`endif
            mosi = data[idx];
            repeat ((i == 0) ? HALF + 4 : HALF) @(negedge clk);
            sclk     = 1'b1;
            got[idx] = miso;
            if (i == 0) begin
                first_bit = miso;
            end
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            if (i == nbits - 1) begin
                cs = 1'b1;
            end
        end
        mosi = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    logic [23:0] got;
    logic        fb;
    int          s_rx, s_und, s_ferr;
    logic        busy_seen;

    initial begin
        rst      = 1'b1;
        cs       = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (5) @(negedge clk);

        // Reset values
        check("rst_miso",      {31'd0, miso},      32'd0);
        check("rst_tx_ready",  {31'd0, tx_ready},  32'd1);
        check("rst_rx_data",   {24'd0, rx_data},   32'h00);
        check("rst_rx_valid",  {31'd0, rx_valid},  32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_flags",     {30'd0, underrun, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Single byte: target sends 0xA5, master sends 0x3C
        preload(8'hA5);
        s_rx = rxv_cnt; s_und = und_cnt; s_ferr = ferr_cnt;
        spi_frame(24'h00003C, 8, got, fb);
        check("b1_rx_data",  {24'd0, rx_data}, 32'h3C);
        check("b1_rx_cnt",   rxv_cnt - s_rx,   32'd1);
        check("b1_miso",     {24'd0, got[7:0]}, 32'hA5);
        check("b1_underrun", und_cnt - s_und,  32'd0);
        check("b1_frame_err", ferr_cnt - s_ferr, 32'd0);
        check("b1_busy",     {31'd0, busy},    32'd0);

        // Three-byte burst in one frame, buffer refilled on tx_ready
        preload(8'h11);
        s_rx = rxv_cnt; s_und = und_cnt; s_ferr = ferr_cnt;
        fork
`ifdef SPI_TARGET_LSB_FIRST_EN
            spi_frame(24'h030201, 24, got, fb);
`else
            spi_frame(24'h010203, 24, got, fb);
`endif
            begin
                supply(8'h22);
                supply(8'h33);
            end
        join
        check("burst_rx_cnt", rxv_cnt - s_rx, 32'd3);
        check("burst_rx0", {24'd0, rx_log[(s_rx + 0) % 16]}, 32'h01);
        check("burst_rx1", {24'd0, rx_log[(s_rx + 1) % 16]}, 32'h02);
        check("burst_rx2", {24'd0, rx_log[(s_rx + 2) % 16]}, 32'h03);
`ifdef SPI_TARGET_LSB_FIRST_EN
        check("burst_miso", {8'd0, got}, 32'h332211);
`else
        check("burst_miso", {8'd0, got}, 32'h112233);
`endif
        check("burst_flags", (und_cnt - s_und) + (ferr_cnt - s_ferr), 32'd0);

        // Underrun: nothing buffered at cs fall
        s_rx = rxv_cnt; s_und = und_cnt; s_ferr = ferr_cnt;
        spi_frame(24'h00005A, 8, got, fb);
        check("und_pulse",   und_cnt - s_und,  32'd1);
        check("und_miso",    {24'd0, got[7:0]}, 32'h00);
        check("und_rx_data", {24'd0, rx_data}, 32'h5A);
        check("und_rx_cnt",  rxv_cnt - s_rx,   32'd1);

        // Abort after five sclk rises
        preload(8'h77);
        s_rx = rxv_cnt; s_und = und_cnt; s_ferr = ferr_cnt;
        spi_frame(24'h00001F, 5, got, fb);
        check("abort_ferr",    ferr_cnt - s_ferr, 32'd1);
        check("abort_rx_cnt",  rxv_cnt - s_rx,    32'd0);
        check("abort_rx_data", {24'd0, rx_data},  32'h5A);
        check("abort_busy",    {31'd0, busy},     32'd0);
        check("abort_und",     und_cnt - s_und,   32'd0);

        // Reset in the middle of a byte, released with cs still low
        preload(8'hE7);
        cs   = 1'b0;
        mosi = 1'b1;
        repeat (HALF + 4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("mrst_miso",     {31'd0, miso},     32'd0);
        check("mrst_busy",     {31'd0, busy},     32'd0);
        check("mrst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("mrst_rx_data",  {24'd0, rx_data},  32'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        s_rx = rxv_cnt; s_und = und_cnt; s_ferr = ferr_cnt;
        busy_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (HALF) begin
                @(negedge clk);
                busy_seen = busy_seen | busy;
            end
            sclk = 1'b1;
            repeat (HALF) begin
                @(negedge clk);
                busy_seen = busy_seen | busy;
            end
            sclk = 1'b0;
        end
        cs = 1'b1;
        repeat (HALF) @(negedge clk);
        check("mrst_no_busy",  {31'd0, busy_seen}, 32'd0);
        check("mrst_no_rx",    rxv_cnt - s_rx,     32'd0);
        check("mrst_no_flags", (und_cnt - s_und) + (ferr_cnt - s_ferr), 32'd0);
        check("mrst_rx_hold",  {24'd0, rx_data},   32'h00);

        // Normal traffic after recovery
        preload(8'hC3);
        s_rx = rxv_cnt;
        spi_frame(24'h000096, 8, got, fb);
        check("rec_rx_data", {24'd0, rx_data},  32'h96);
        check("rec_miso",    {24'd0, got[7:0]}, 32'hC3);
        check("rec_rx_cnt",  rxv_cnt - s_rx,    32'd1);

`ifdef SPI_TARGET_LSB_FIRST_EN
        // LSB-first: 0x01 goes out bit 0 first, 0x80 arrives bit 0 first
        preload(8'h01);
        spi_frame(24'h000080, 8, got, fb);
        check("lsb_first_bit", {31'd0, fb},      32'd1);
        check("lsb_rx_data",   {24'd0, rx_data}, 32'h80);
        check("lsb_miso",      {24'd0, got[7:0]}, 32'h01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
